// File: rtl/mult_seq.sv
// Iterative shift-add multiplier for MULT/MULTU: retires STEP multiplier bits per
// cycle on operand magnitudes, then applies the sign once in the final cycle.
module mult_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sign,
  input  logic                 cancel,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int ZW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((WIDTH % STEP) != 0) begin : g_step_check
      $error("mult_seq: STEP must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [ZW-1:0]     z_reg;
  logic [ZW-1:0]     acc_reg;
  logic [ZW-1:0]     mcand_reg;
  logic [WIDTH-1:0]  mplier_reg;
  logic [CW-1:0]     count_reg;
  logic              neg_reg;

  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [ZW-1:0]     pp_term [STEP];
  logic [ZW-1:0]     pp_sum;

  // The most negative input negates to itself, which is the correct unsigned magnitude.
  assign a_mag = (sign && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (sign && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // The multiplicand register is pre-shifted each cycle, so each digit bit only
  // needs a fixed offset within the current STEP-wide window.
  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
      assign pp_term[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < STEP; i++) begin
      pp_sum = pp_sum + pp_term[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      z_reg      <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      neg_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !cancel) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            neg_reg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_reg    <= '0;
            count_reg  <= '0;
            state_reg  <= CALC;
            busy_reg   <= 1'b1;
          end
        end
        CALC: begin
          if (cancel) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            acc_reg    <= acc_reg + pp_sum;
            mcand_reg  <= mcand_reg << STEP;
            mplier_reg <= mplier_reg >> STEP;
            count_reg  <= count_reg + CW'(1);
            if (count_reg == LAST) begin
              state_reg <= FIN;
            end
          end
        end
        FIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (!cancel) begin
            z_reg    <= neg_reg ? (ZW'(0) - acc_reg) : acc_reg;
            done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign z    = z_reg;

endmodule

// File: tb/tb_mult_seq.sv
// Directed and randomised checks of mult_seq at STEP = 1, 4 and 8 (WIDTH = 32),
// three instances sharing operand, reset and cancel inputs.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        sign;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  start_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [63:0] z0, z1, z2;

  int checks   = 0;
  int failures = 0;
  int lat [3]  = '{33, 9, 5};

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .sign(sign), .cancel(cancel),
    .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]), .z(z0));
  mult_seq #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .sign(sign), .cancel(cancel),
    .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]), .z(z1));
  mult_seq #(.WIDTH(32), .STEP(8)) u_s8 (
    .clk(clk), .reset(reset), .start(start_v[2]), .sign(sign), .cancel(cancel),
    .a(a), .b(b), .busy(busy_v[2]), .done(done_v[2]), .z(z2));

  function automatic logic [63:0] get_z(input int k);
    case (k)
      0:       return z0;
      1:       return z1;
      default: return z2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation on instance k and follow it to done, scrambling the
  // operands and sign right after capture.
  task automatic run_op(input int k, input logic sg, input logic [31:0] aa,
                        input logic [31:0] bb, output logic [63:0] zo,
                        output int bcyc, output bit ok);
    sign       = sg;
    a          = aa;
    b          = bb;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    a          = $urandom;
    b          = $urandom;
    sign       = ~sg;
    bcyc       = 0;
    ok         = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (busy_v[k]) bcyc++;
      if (done_v[k]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    zo = get_z(k);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL run_op_timeout inst=%0d got no done within 100 cycles", k);
    end
    $display("op inst=%0d sign=%0d a=%h b=%h z=%h busy_cycles=%0d", k, sg, aa, bb, zo, bcyc);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    start_v = 3'b111;
    tick();
    tick();
    start_v = 3'b000;
    reset   = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || get_z(k) !== 64'd0) begin
        failures++;
        $display("FAIL reset_state inst=%0d busy=%b done=%b z=%h required 0 0 0",
                 k, busy_v[k], done_v[k], get_z(k));
      end
    end
    $display("reset released, all instances idle");
  endtask

  task automatic test_unsigned_max(input int k);
    logic [63:0] zr;
    int          bc;
    bit          ok;
    run_op(k, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, zr, bc, ok);
    checks++;
    if (zr !== 64'hFFFF_FFFE_0000_0001) begin
      failures++;
      $display("FAIL umax_z inst=%0d got %h required fffffffe00000001", k, zr);
    end
    checks++;
    if (bc !== lat[k]) begin
      failures++;
      $display("FAIL umax_latency inst=%0d got %0d required %0d", k, bc, lat[k]);
    end
    tick();
    checks++;
    if (done_v[k] !== 1'b0 || get_z(k) !== 64'hFFFF_FFFE_0000_0001) begin
      failures++;
      $display("FAIL done_pulse inst=%0d done=%b z=%h required 0 and stable z", k, done_v[k], get_z(k));
    end
  endtask

  task automatic test_signed(input int k);
    logic [63:0] zr;
    int          bc;
    bit          ok;
    run_op(k, 1'b1, 32'hFFFF_FFFD, 32'd5, zr, bc, ok);
    checks++;
    if (zr !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      failures++;
      $display("FAIL signed_neg3x5 inst=%0d got %h required fffffffffffffff1", k, zr);
    end
    run_op(k, 1'b1, 32'h8000_0000, 32'h8000_0000, zr, bc, ok);
    checks++;
    if (zr !== 64'h4000_0000_0000_0000) begin
      failures++;
      $display("FAIL signed_minsq inst=%0d got %h required 4000000000000000", k, zr);
    end
    run_op(k, 1'b0, 32'h8000_0000, 32'h8000_0000, zr, bc, ok);
    checks++;
    if (zr !== 64'h4000_0000_0000_0000) begin
      failures++;
      $display("FAIL unsigned_minsq inst=%0d got %h required 4000000000000000", k, zr);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] zr;
    int          bc;
    bit          ok;
    bit          z_moved;
    run_op(0, 1'b0, 32'd7, 32'd6, zr, bc, ok);
    checks++;
    if (zr !== 64'h2A) begin
      failures++;
      $display("FAIL b2b_first got %h required 2a", zr);
    end
    // Still in the done cycle: issue the next request immediately.
    sign       = 1'b0;
    a          = 32'h0001_0000;
    b          = 32'h0001_0000;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept busy=%b required 1", busy_v[0]);
    end
    bc      = 1;
    ok      = 1'b0;
    z_moved = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c == 5) begin
        a          = 32'd5;
        b          = 32'd5;
        start_v[0] = 1'b1;
      end else begin
        start_v[0] = 1'b0;
      end
      tick();
      if (busy_v[0]) bc++;
      if (done_v[0]) begin
        ok = 1'b1;
        break;
      end
      if (z0 !== 64'h2A) z_moved = 1'b1;
    end
    start_v[0] = 1'b0;
    $display("op inst=0 b2b a=00010000 b=00010000 z=%h busy_cycles=%0d", z0, bc);
    checks++;
    if (!ok || z0 !== 64'h0000_0001_0000_0000) begin
      failures++;
      $display("FAIL b2b_second done=%b z=%h required 1 and 0000000100000000", ok, z0);
    end
    checks++;
    if (z_moved || bc !== 33) begin
      failures++;
      $display("FAIL b2b_hold z_moved=%b busy_cycles=%0d required 0 and 33", z_moved, bc);
    end
    tick();
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ignored_start busy=%b done=%b required 0 0", busy_v[0], done_v[0]);
    end
  endtask

  task automatic test_cancel();
    logic [63:0] zr;
    logic [63:0] prev;
    int          bc;
    bit          ok;
    bit          saw_done;
    prev       = z0;
    sign       = 1'b0;
    a          = 32'h1234;
    b          = 32'h5678;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    $display("op inst=0 cancel at iteration 10 busy=%b done=%b z=%h", busy_v[0], done_v[0], z0);
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || z0 !== prev) begin
      failures++;
      $display("FAIL cancel_abort busy=%b done=%b z=%h required 0 0 %h", busy_v[0], done_v[0], z0, prev);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_v[0] || z0 !== prev) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL cancel_no_done got a done or z change after cancel, required none");
    end
    run_op(0, 1'b0, 32'd3, 32'd4, zr, bc, ok);
    checks++;
    if (zr !== 64'hC || bc !== 33) begin
      failures++;
      $display("FAIL cancel_next z=%h busy_cycles=%0d required c and 33", zr, bc);
    end
  endtask

  task automatic test_reset_mid();
    sign       = 1'b0;
    a          = 32'hFFFF;
    b          = 32'hFFFF;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    reset      = 1'b0;
    start_v[0] = 1'b1;
    tick();
    $display("op inst=0 reset mid-calc busy=%b done=%b z=%h", busy_v[0], done_v[0], z0);
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || z0 !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b z=%h required 0 0 0", busy_v[0], done_v[0], z0);
    end
    reset      = 1'b1;
    start_v[0] = 1'b0;
    tick();
    checks++;
    if (busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored busy=%b required 0", busy_v[0]);
    end
  endtask

  task automatic test_random();
    logic [63:0] zr;
    logic [63:0] ref_z;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          bc;
    bit          ok;
    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (rs)
        ref_z = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
      else
        ref_z = {32'd0, ra} * {32'd0, rb};
      run_op(i % 3, rs, ra, rb, zr, bc, ok);
      checks++;
      if (zr !== ref_z || bc !== lat[i % 3]) begin
        failures++;
        $display("FAIL random_%0d inst=%0d z=%h cycles=%0d required %h and %0d",
                 i, i % 3, zr, bc, ref_z, lat[i % 3]);
      end
      tick();
    end
  endtask

  initial begin
    reset   = 1'b0;
    cancel  = 1'b0;
    start_v = 3'b000;
    sign    = 1'b0;
    a       = '0;
    b       = '0;
    test_reset();
    for (int k = 0; k < 3; k++) begin
      test_unsigned_max(k);
      test_signed(k);
    end
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
